// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory read port, redirect input and dequeue port.
interface fetch_queue_if #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned CNT_W   = 3
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               deq_valid;
  logic               deq_ready;
  logic [INSTR_W-1:0] deq_instr;
  logic [ADDR_W-1:0]  deq_pc;
  logic [CNT_W-1:0]   count;

  // Fetch queue side
  modport master (
    output imem_req, imem_addr, deq_valid, deq_instr, deq_pc, count,
    input  imem_rvalid, imem_rdata, redirect, redirect_pc, deq_ready
  );

  // Memory / register-fetch side
  modport slave (
    input  imem_req, imem_addr, deq_valid, deq_instr, deq_pc, count,
    output imem_rvalid, imem_rdata, redirect, redirect_pc, deq_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues 1-cycle-latency imem reads
// and buffers {pc, instr} pairs in a small FIFO; redirects flush and restart fetch.
module fetch_queue #(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           reset,
  fetch_queue_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic {BOOT, RUN} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  req_pc_q;
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               inflight_q;
  entry_t             mem_q [DEPTH];

  logic               issue_c, enq_c, deq_c, valid_c;
  logic [SUM_W-1:0]   credits_c;
  entry_t             head_c;

  // Next state plus issue/enqueue/dequeue decisions; redirect blocks all three
  always_comb begin
    state_d   = state_q;
    issue_c   = 1'b0;
    enq_c     = 1'b0;
    valid_c   = 1'b0;
    deq_c     = 1'b0;
    credits_c = SUM_W'(count_q) + SUM_W'(inflight_q);
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        issue_c = !bus.redirect && (credits_c < SUM_W'(DEPTH));
        enq_c   = bus.imem_rvalid && inflight_q && !bus.redirect;
        valid_c = (count_q != '0) && !bus.redirect;
        deq_c   = valid_c && bus.deq_ready;
      end
      default: state_d = BOOT;
    endcase
  end

  assign head_c        = mem_q[rd_ptr_q];
  assign bus.imem_req  = issue_c;
  assign bus.imem_addr = pc_q;
  assign bus.deq_valid = valid_c;
  assign bus.deq_instr = (count_q != '0) ? head_c.instr : '0;
  assign bus.deq_pc    = (count_q != '0) ? head_c.pc : '0;
  assign bus.count     = count_q;

  // Control state: PC, pointers, occupancy and outstanding-request flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.redirect) begin
        pc_q       <= bus.redirect_pc;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        count_q    <= '0;
        inflight_q <= 1'b0;
      end else begin
        inflight_q <= issue_c;
        if (issue_c) begin
          pc_q     <= pc_q + ADDR_W'(4);
          req_pc_q <= pc_q;
        end
        if (enq_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (deq_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(enq_c) - CNT_W'(deq_c);
      end
    end
  end

  // Queue storage; contents are only visible while count is non-zero
  always_ff @(posedge clk) begin
    if (enq_c) mem_q[wr_ptr_q] <= {req_pc_q, bus.imem_rdata};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a scoreboard of expected {pc, instr} pairs.
module tb_fetch_queue;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();
  fetch_queue_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus2 ();

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W),
                .RESET_PC(64'h0)) dut (.clk(clk), .reset(reset), .bus(bus));
  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W),
                .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];
  logic [63:0] q5 [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction memories: respond one cycle after each request, echoing the address
  always @(posedge clk) begin
    bus.imem_rvalid  <= bus.imem_req;
    bus.imem_rdata   <= bus.imem_addr[31:0];
    bus2.imem_rvalid <= bus2.imem_req;
    bus2.imem_rdata  <= bus2.imem_addr[31:0];
  end

  // Scoreboard: push on request, flush on redirect/reset, pop and compare on handshake
  always @(negedge clk) begin
    logic [63:0] e;
    if (!reset || bus.redirect) begin
      exp_q.delete();
    end else begin
      if (bus.imem_req) exp_q.push_back(bus.imem_addr);
      if (bus.deq_valid && bus.deq_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_nonempty", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_deq_pc", bus.deq_pc, e);
          chk("sb_deq_instr", 64'(bus.deq_instr), 64'(e[31:0]));
        end
      end
    end
    chk("count_le_depth", 64'(bus.count <= 3'd4), 64'd1);
  end

  // Record the first request addresses of the wrapping-PC instance
  always @(negedge clk) begin
    if (reset && bus2.imem_req && q5.size() < 4) q5.push_back(bus2.imem_addr);
  end

  initial begin
    logic [63:0] e5 [4];
    bit found;
    e5[0] = 64'hFFFF_FFFF_FFFF_FFF8;
    e5[1] = 64'hFFFF_FFFF_FFFF_FFFC;
    e5[2] = 64'h0;
    e5[3] = 64'h4;

    reset = 1'b0;
    bus.redirect = 1'b0;  bus.redirect_pc = '0;  bus.deq_ready = 1'b0;
    bus2.redirect = 1'b0; bus2.redirect_pc = '0; bus2.deq_ready = 1'b1;
    #2;
    chk("rst_req", 64'(bus.imem_req), 64'd0);
    chk("rst_valid", 64'(bus.deq_valid), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_pc", bus.deq_pc, 64'd0);
    chk("rst_instr", 64'(bus.deq_instr), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("boot_no_req", 64'(bus.imem_req), 64'd0);

    // Fill with no consumer: four requests then stall on credits
    step();
    for (int i = 0; i < 4; i++) begin
      chk("fill_req", 64'(bus.imem_req), 64'd1);
      chk("fill_addr", bus.imem_addr, 64'(4 * i));
      step();
    end
    chk("full_no_req_a", 64'(bus.imem_req), 64'd0);
    step();
    chk("full_no_req_b", 64'(bus.imem_req), 64'd0);
    chk("full_count", 64'(bus.count), 64'd4);
    chk("full_valid", 64'(bus.deq_valid), 64'd1);
    chk("full_head_pc", bus.deq_pc, 64'h0);
    chk("full_head_instr", 64'(bus.deq_instr), 64'h0);

    // Stream with steady consumer: one entry per cycle, no gaps
    bus.deq_ready = 1'b1;
    #1;
    for (int k = 0; k < 16; k++) begin
      chk("stream_valid", 64'(bus.deq_valid), 64'd1);
      chk("stream_pc", bus.deq_pc, 64'(4 * k));
      step();
    end

    // Restart at 0, then redirect while the response for 0x10 is arriving
    bus.redirect = 1'b1; bus.redirect_pc = 64'h0;
    step();
    bus.redirect = 1'b0;
    #1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (bus.imem_req && bus.imem_addr == 64'h10) found = 1'b1;
      else begin step(); #1; end
    end
    chk("req_0x10_seen", 64'(found), 64'd1);
    step();
    bus.redirect = 1'b1; bus.redirect_pc = 64'h100;
    #1;
    chk("resp_0x10_valid", 64'(bus.imem_rvalid), 64'd1);
    chk("resp_0x10_data", 64'(bus.imem_rdata), 64'h10);
    chk("redir_no_req", 64'(bus.imem_req), 64'd0);
    chk("redir_no_valid", 64'(bus.deq_valid), 64'd0);
    step();
    bus.redirect = 1'b0;
    #1;
    chk("redir_count", 64'(bus.count), 64'd0);
    chk("redir_req", 64'(bus.imem_req), 64'd1);
    chk("redir_addr", bus.imem_addr, 64'h100);
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      if (bus.deq_valid) found = 1'b1;
      else begin step(); #1; end
    end
    chk("redir_valid_seen", 64'(found), 64'd1);
    chk("redir_head_pc", bus.deq_pc, 64'h100);

    // Redirect together with deq_ready at count=2: no handshake, queue flushed
    bus.deq_ready = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      step(); #1;
      if (bus.count == 3'd2) found = 1'b1;
    end
    chk("count2_seen", 64'(found), 64'd1);
    bus.deq_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 64'h200;
    #1;
    chk("redir2_no_valid", 64'(bus.deq_valid), 64'd0);
    chk("redir2_no_req", 64'(bus.imem_req), 64'd0);
    step();
    bus.redirect = 1'b0; bus.deq_ready = 1'b0;
    #1;
    chk("redir2_count", 64'(bus.count), 64'd0);
    chk("redir2_addr", bus.imem_addr, 64'h200);

    // Asynchronous reset mid-stream with count=3
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      step(); #1;
      if (bus.count == 3'd3) found = 1'b1;
    end
    chk("count3_seen", 64'(found), 64'd1);
    reset = 1'b0;
    #1;
    chk("arst_req", 64'(bus.imem_req), 64'd0);
    chk("arst_valid", 64'(bus.deq_valid), 64'd0);
    chk("arst_count", 64'(bus.count), 64'd0);
    chk("arst_pc", bus.deq_pc, 64'd0);
    chk("arst_instr", 64'(bus.deq_instr), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reboot_no_req", 64'(bus.imem_req), 64'd0);
    step();
    chk("reboot_req", 64'(bus.imem_req), 64'd1);
    chk("reboot_addr", bus.imem_addr, 64'h0);
    bus.deq_ready = 1'b1;
    repeat (12) step();

    // Fetch PC wraps past the top of the address space
    chk("wrap_count", 64'(q5.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk("wrap_addr", (i < q5.size()) ? q5[i] : 64'hDEAD, e5[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
